// File: rtl/pool_pkg.sv
// Shared definitions for the pooling sequencer: FSM states, pool-size
// encodings and default widths.
package pool_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DIM_WIDTH  = 4;

  // Headroom bits above DATA_WIDTH so a 4x4 window sum cannot overflow.
  localparam int ACC_GUARD_BITS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_FIN
  } state_t;

  // Window side is 1 << encoding; the top encoding is reserved as illegal.
  typedef enum logic [1:0] {
    POOL_1       = 2'd0,
    POOL_2       = 2'd1,
    POOL_4       = 2'd2,
    POOL_ILLEGAL = 2'd3
  } pool_log2_t;

  function automatic logic [3:0] pool_side(input logic [1:0] log2);
    return 4'd1 << log2;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/offset counters and the read/write address arithmetic for the
// pooling sequencer. Counters always point at the next read to issue.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_step_off,
  input  logic                  i_step_win,
  input  logic [1:0]            i_pool_log2,
  input  logic [DIM_WIDTH-1:0]  i_stride,
  input  logic [DIM_WIDTH-1:0]  i_dim,
  input  logic [DIM_WIDTH-1:0]  i_out_dim,
  input  logic [ADDR_WIDTH-1:0] i_in_addr,
  input  logic [ADDR_WIDTH-1:0] i_out_addr,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_first_off,
  output logic                  o_last_off,
  output logic                  o_last_win
);

  localparam int WIN_W = 2 * DIM_WIDTH;

  logic [1:0]            r_wr;
  logic [1:0]            r_wc;
  logic [DIM_WIDTH-1:0]  r_orow;
  logic [DIM_WIDTH-1:0]  r_ocol;
  logic [WIN_W-1:0]      r_win_idx;

  logic [1:0]            w_pool_m1;
  logic [DIM_WIDTH-1:0]  w_out_m1;
  logic [ADDR_WIDTH-1:0] w_row;
  logic [ADDR_WIDTH-1:0] w_col;

  assign w_pool_m1 = 2'(pool_side(i_pool_log2) - 4'd1);
  assign w_out_m1  = i_out_dim - DIM_WIDTH'(1);

  // Step the in-window offset (wc fastest) and the window position (ocol fastest).
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all counters update from the
    // pre-edge values together; blocking = would let later lines see new values.
    if (rst || i_clear) begin
      r_wr      <= '0;
      r_wc      <= '0;
      r_orow    <= '0;
      r_ocol    <= '0;
      r_win_idx <= '0;
    end else begin
      if (i_step_off) begin
        if (r_wc == w_pool_m1) begin
          r_wc <= '0;
          r_wr <= (r_wr == w_pool_m1) ? 2'd0 : r_wr + 2'd1;
        end else begin
          r_wc <= r_wc + 2'd1;
        end
      end
      if (i_step_win) begin
        r_win_idx <= r_win_idx + WIN_W'(1);
        if (r_ocol == w_out_m1) begin
          r_ocol <= '0;
          r_orow <= r_orow + DIM_WIDTH'(1);
        end else begin
          r_ocol <= r_ocol + DIM_WIDTH'(1);
        end
      end
    end
  end

  // All address terms are carried at ADDR_WIDTH so the sums wrap naturally.
  assign w_row     = ADDR_WIDTH'(r_orow) * ADDR_WIDTH'(i_stride) + ADDR_WIDTH'(r_wr);
  assign w_col     = ADDR_WIDTH'(r_ocol) * ADDR_WIDTH'(i_stride) + ADDR_WIDTH'(r_wc);
  assign o_rd_addr = i_in_addr + w_row * ADDR_WIDTH'(i_dim) + w_col;
  assign o_wr_addr = i_out_addr + ADDR_WIDTH'(r_win_idx);

  assign o_first_off = (r_wr == 2'd0) && (r_wc == 2'd0);
  assign o_last_off  = (r_wr == w_pool_m1) && (r_wc == w_pool_m1);
  assign o_last_win  = (r_orow == w_out_m1) && (r_ocol == w_out_m1);

endmodule

// File: rtl/pool_sequencer.sv
// Average-pooling job sequencer: accepts a descriptor, streams pool x pool
// reads per output window from a shared memory, sums them and writes the
// mean back, one window after another with no idle gap.
module pool_sequencer
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_pool_log2,
  input  logic [DIM_WIDTH-1:0]  cmd_stride,
  input  logic [DIM_WIDTH-1:0]  cmd_dim,
  input  logic [ADDR_WIDTH-1:0] cmd_in_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_out_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int ACC_WIDTH = DATA_WIDTH + ACC_GUARD_BITS;
  localparam int CMP_W     = (DIM_WIDTH > 4) ? DIM_WIDTH : 4;

  state_t                r_state;
  pool_log2_t            r_pool_log2;
  logic [DIM_WIDTH-1:0]  r_stride;
  logic [DIM_WIDTH-1:0]  r_dim;
  logic [DIM_WIDTH-1:0]  r_out_dim;
  logic [ADDR_WIDTH-1:0] r_in_addr;
  logic [ADDR_WIDTH-1:0] r_out_addr;

  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
  logic                  r_iss_first;
  logic                  r_last_iss;
  logic                  r_rd_vld;
  logic                  r_rd_first;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  r_mem_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
  logic [DATA_WIDTH-1:0] r_mem_wr_data;
  logic                  r_last_win;
  logic                  r_done;
  logic                  r_err;

  logic [3:0]            w_pool;
  logic                  w_illegal;
  logic [DIM_WIDTH-1:0]  w_out_dim;
  logic [2:0]            w_shift;
  logic [ACC_WIDTH-1:0]  w_acc_next;
  logic [DATA_WIDTH-1:0] w_avg;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_step_win;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_first_off;
  logic                  w_last_off;
  logic                  w_last_win;

  assign w_pool    = pool_side(r_pool_log2);
  assign w_illegal = (r_stride == '0) || (r_dim == '0) ||
                     (r_pool_log2 == POOL_ILLEGAL) ||
                     (CMP_W'(w_pool) > CMP_W'(r_dim));
  // Only consumed when the job is legal, so stride is never zero here.
  assign w_out_dim = (r_dim - DIM_WIDTH'(w_pool)) / r_stride + DIM_WIDTH'(1);

  // Dividing by pool*pool is a shift by twice the pool encoding.
  assign w_shift    = {r_pool_log2, 1'b0};
  assign w_acc_next = (r_rd_first ? '0 : r_acc) + ACC_WIDTH'(mem_rd_data);
  assign w_avg      = DATA_WIDTH'(w_acc_next >> w_shift);

  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_issue    = ((r_state == S_CHECK) && !w_illegal) ||
                      ((r_state == S_READ)  && !r_last_iss) ||
                      ((r_state == S_WRITE) && !r_last_win);
  // The window advances while draining, so its first read can issue from WRITE.
  assign w_step_win = (r_state == S_DRAIN);

  pool_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_accept),
    .i_step_off  (w_issue),
    .i_step_win  (w_step_win),
    .i_pool_log2 (r_pool_log2),
    .i_stride    (r_stride),
    .i_dim       (r_dim),
    .i_out_dim   (r_out_dim),
    .i_in_addr   (r_in_addr),
    .i_out_addr  (r_out_addr),
    .o_rd_addr   (w_rd_addr),
    .o_wr_addr   (w_wr_addr),
    .o_first_off (w_first_off),
    .o_last_off  (w_last_off),
    .o_last_win  (w_last_win)
  );

  // FSM with registered memory strobes, result pulses and the window accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pool_log2   <= POOL_1;
      r_stride      <= '0;
      r_dim         <= '0;
      r_out_dim     <= '0;
      r_in_addr     <= '0;
      r_out_addr    <= '0;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_iss_first   <= 1'b0;
      r_last_iss    <= 1'b0;
      r_rd_vld      <= 1'b0;
      r_rd_first    <= 1'b0;
      r_acc         <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_last_win    <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;

      // Read data returns one cycle after the strobe; track it alongside.
      r_rd_vld   <= r_mem_rd_en;
      r_rd_first <= r_iss_first;
      if (r_rd_vld) r_acc <= w_acc_next;

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_pool_log2 <= pool_log2_t'(cmd_pool_log2);
            r_stride    <= cmd_stride;
            r_dim       <= cmd_dim;
            r_in_addr   <= cmd_in_addr;
            r_out_addr  <= cmd_out_addr;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_illegal) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_out_dim <= w_out_dim;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          if (r_last_iss) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_mem_wr_en   <= 1'b1;
          r_mem_wr_addr <= w_wr_addr;
          r_mem_wr_data <= w_avg;
          r_last_win    <= w_last_win;
          r_state       <= S_WRITE;
        end
        S_WRITE: begin
          if (r_last_win) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_READ;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_issue) begin
        r_mem_rd_en   <= 1'b1;
        r_mem_rd_addr <= w_rd_addr;
        r_iss_first   <= w_first_off;
        r_last_iss    <= w_last_off;
      end
    end
  end

  // Gated by rst so ready is low throughout reset yet high on the very
  // first cycle after it is released.
  assign cmd_ready   = (r_state == S_IDLE) && !rst;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err         = r_err;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_pool_sequencer.sv
// Bench for pool_sequencer: a table of job descriptors with expected
// outcome, a reference model feeding read/write scoreboards, and
// hand-written sequences for timing, busy-ignore and mid-job reset.
module tb_pool_sequencer;

  typedef struct {
    logic [1:0]  pl2;
    logic [3:0]  stride;
    logic [3:0]  dim;
    logic [11:0] in_a;
    logic [11:0] out_a;
    bit          exp_err;
    int          exp_nwr;
  } job_t;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_pool_log2;
  logic [3:0]  cmd_stride;
  logic [3:0]  cmd_dim;
  logic [11:0] cmd_in_addr;
  logic [11:0] cmd_out_addr;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [11:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic        done;
  logic        err;

  pool_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_pool_log2 (cmd_pool_log2),
    .cmd_stride    (cmd_stride),
    .cmd_dim       (cmd_dim),
    .cmd_in_addr   (cmd_in_addr),
    .cmd_out_addr  (cmd_out_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 32'hDEADBEEF;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [11:0] rd_q[$];
  wr_t         wr_q[$];
  logic [11:0] rlog[$];
  wr_t         wlog[$];
  int          n_rd, n_wr;
  bit          saw_done, saw_err;
  int          first_rd_cyc, last_wr_cyc, done_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name, input logic [63:0] act);
    n_vec++;
    n_miss++;
    $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Output monitor: compares every read and write against the scoreboards.
  always @(negedge clk) begin
    logic [11:0] ea;
    wr_t         ew;
    if (!rst) begin
      if (mem_rd_en && mem_wr_en) flag_unexpected("rd_wr_same_cycle", {mem_rd_addr, mem_wr_addr});
      if (mem_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        n_rd++;
        rlog.push_back(mem_rd_addr);
        if (rd_q.size() == 0) flag_unexpected("rd_unexpected", mem_rd_addr);
        else begin
          ea = rd_q.pop_front();
          check("rd_addr", mem_rd_addr, ea);
        end
      end
      if (mem_wr_en) begin
        last_wr_cyc = cyc;
        n_wr++;
        wlog.push_back('{mem_wr_addr, mem_wr_data});
        if (wr_q.size() == 0) flag_unexpected("wr_unexpected", mem_wr_addr);
        else begin
          ew = wr_q.pop_front();
          check("wr_addr", mem_wr_addr, ew.a);
          check("wr_data", mem_wr_data, ew.d);
        end
      end
      if (done) begin saw_done = 1'b1; done_cyc = cyc; end
      if (err) saw_err = 1'b1;
    end
  end

  task automatic clear_obs();
    rlog.delete();
    wlog.delete();
    n_rd = 0; n_wr = 0;
    saw_done = 1'b0; saw_err = 1'b0;
    first_rd_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
  endtask

  // Reference model: average of each pool x pool window, row-major windows.
  task automatic model_job(input job_t j);
    int pool, od, a;
    longint unsigned sum;
    if (j.exp_err) return;
    pool = 1 << j.pl2;
    od = (int'(j.dim) - pool) / int'(j.stride) + 1;
    for (int orow = 0; orow < od; orow++)
      for (int ocol = 0; ocol < od; ocol++) begin
        sum = 0;
        for (int wr = 0; wr < pool; wr++)
          for (int wc = 0; wc < pool; wc++) begin
            a = (int'(j.in_a) + (orow * int'(j.stride) + wr) * int'(j.dim)
                 + ocol * int'(j.stride) + wc) & 'hFFF;
            rd_q.push_back(12'(a));
            sum += longint'(mem[a]);
          end
        wr_q.push_back('{12'((int'(j.out_a) + orow * od + ocol) & 'hFFF),
                         32'(sum >> (2 * j.pl2))});
      end
  endtask

  task automatic run_job(input job_t j, input bit spam);
    int  pool;
    bit  got;
    pool = 1 << j.pl2;
    clear_obs();
    model_job(j);
    for (int k = 0; k < 10 && !cmd_ready; k++) @(negedge clk);
    check("cmd_ready_before_job", cmd_ready, 1);
    cmd_valid     = 1'b1;
    cmd_pool_log2 = j.pl2;
    cmd_stride    = j.stride;
    cmd_dim       = j.dim;
    cmd_in_addr   = j.in_a;
    cmd_out_addr  = j.out_a;
    @(negedge clk);
    if (spam) begin
      // A legal one-read job held on the port while busy must be ignored.
      cmd_pool_log2 = 2'd0; cmd_stride = 4'd1; cmd_dim = 4'd1;
      cmd_in_addr = 12'h700; cmd_out_addr = 12'h7F0;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int k = 0; k < 2000; k++) begin
      #1;
      if (saw_done || saw_err) break;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("done_seen", saw_done, !j.exp_err);
    check("err_seen", saw_err, j.exp_err);
    check("write_count", n_wr, j.exp_nwr);
    check("read_count", n_rd, j.exp_nwr * pool * pool);
    check("rd_q_left", rd_q.size(), 0);
    check("wr_q_left", wr_q.size(), 0);
    if (j.exp_err) begin
      got = 1'b0;
      for (int k = 0; k < 2 && !got; k++) begin
        if (cmd_ready) got = 1'b1;
        else @(negedge clk);
      end
      check("ready_after_err", got, 1);
    end else begin
      check("job_latency", done_cyc - first_rd_cyc, j.exp_nwr * (pool * pool + 2));
      check("done_after_last_wr", done_cyc - last_wr_cyc, 1);
      @(negedge clk);
    end
    rd_q.delete();
    wr_q.delete();
  endtask

  job_t jobs[11];

  initial begin
    bit hit;
    jobs[0]  = '{2'd1, 4'd2, 4'd4,  12'h000, 12'h100, 1'b0, 4};
    jobs[1]  = '{2'd1, 4'd1, 4'd3,  12'h010, 12'h110, 1'b0, 4};
    jobs[2]  = '{2'd1, 4'd0, 4'd4,  12'h000, 12'h100, 1'b1, 0};
    jobs[3]  = '{2'd3, 4'd1, 4'd4,  12'h000, 12'h100, 1'b1, 0};
    jobs[4]  = '{2'd1, 4'd1, 4'd1,  12'h000, 12'h100, 1'b1, 0};
    jobs[5]  = '{2'd1, 4'd1, 4'd2,  12'hFFE, 12'h120, 1'b0, 1};
    jobs[6]  = '{2'd2, 4'd1, 4'd4,  12'h200, 12'h130, 1'b0, 1};
    jobs[7]  = '{2'd0, 4'd1, 4'd3,  12'h020, 12'h140, 1'b0, 9};
    jobs[8]  = '{2'd2, 4'd3, 4'd9,  12'h300, 12'h150, 1'b0, 4};
    jobs[9]  = '{2'd0, 4'd1, 4'd0,  12'h000, 12'h100, 1'b1, 0};
    jobs[10] = '{2'd1, 4'd3, 4'd15, 12'h400, 12'h160, 1'b0, 25};

    for (int i = 0; i < 4096; i++) begin
      if (i < 'h200) mem[i] = 32'(i);
      else if (i < 'h210) mem[i] = 32'hFFFF_FFFF;
      else mem[i] = $urandom;
    end

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_pool_log2 = '0; cmd_stride = '0; cmd_dim = '0;
    cmd_in_addr = '0; cmd_out_addr = '0;
    clear_obs();
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_job(jobs[i], i == 7);
      case (i)
        0: begin
          check("j0_nlog", wlog.size(), 4);
          if (wlog.size() == 4) begin
            check("j0_w0_addr", wlog[0].a, 12'h100); check("j0_w0_data", wlog[0].d, 2);
            check("j0_w1_addr", wlog[1].a, 12'h101); check("j0_w1_data", wlog[1].d, 4);
            check("j0_w2_addr", wlog[2].a, 12'h102); check("j0_w2_data", wlog[2].d, 10);
            check("j0_w3_addr", wlog[3].a, 12'h103); check("j0_w3_data", wlog[3].d, 12);
          end
        end
        1: begin
          check("j1_nrlog", rlog.size(), 16);
          if (rlog.size() >= 4) begin
            check("j1_r0", rlog[0], 12'h010); check("j1_r1", rlog[1], 12'h011);
            check("j1_r2", rlog[2], 12'h013); check("j1_r3", rlog[3], 12'h014);
          end
        end
        5: begin
          check("j5_nrlog", rlog.size(), 4);
          if (rlog.size() == 4) begin
            check("j5_r0", rlog[0], 12'hFFE); check("j5_r1", rlog[1], 12'hFFF);
            check("j5_r2", rlog[2], 12'h000); check("j5_r3", rlog[3], 12'h001);
          end
        end
        6: if (wlog.size() == 1) check("j6_saturated_avg", wlog[0].d, 32'hFFFF_FFFF);
        default: ;
      endcase
    end

    // Reset in the middle of window 1's reads.
    clear_obs();
    model_job(jobs[0]);
    for (int k = 0; k < 10 && !cmd_ready; k++) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_pool_log2 = jobs[0].pl2; cmd_stride = jobs[0].stride; cmd_dim = jobs[0].dim;
    cmd_in_addr = jobs[0].in_a; cmd_out_addr = jobs[0].out_a;
    @(negedge clk);
    cmd_valid = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      #1;
      if (n_rd >= 6) hit = 1'b1;
      else @(negedge clk);
    end
    check("reached_window1", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", mem_rd_en, 0);
    check("midrst_wr_en", mem_wr_en, 0);
    check("midrst_done", done, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    rd_q.delete();
    wr_q.delete();
    clear_obs();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_ready_after", cmd_ready, 1);
    repeat (20) @(negedge clk);
    #1;
    check("midrst_no_writes", n_wr, 0);
    check("midrst_no_reads", n_rd, 0);
    check("midrst_no_done", saw_done, 0);
    run_job(jobs[0], 1'b0);
    if (wlog.size() == 4) check("post_rst_w3_data", wlog[3].d, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pool_sequencer.md
POOL_SEQUENCER -- requirements
Module: pool_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word address width of the shared feature-map memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, unsigned element width.
REQ-003 SHALL have parameter DIM_WIDTH, default 4, width of dimension and stride fields.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cmd_valid in 1 and cmd_ready out 1, the job-descriptor handshake.
REQ-007 SHALL have port cmd_pool_log2  in  2  window side is 1<<cmd_pool_log2 (1, 2 or 4); value 3 is illegal.
REQ-008 SHALL have ports cmd_stride, cmd_dim  in  DIM_WIDTH, the window step and the square input side.
REQ-009 SHALL have ports cmd_in_addr, cmd_out_addr  in  ADDR_WIDTH, the input and output map base addresses.
REQ-010 SHALL have ports mem_rd_en out 1, mem_rd_addr out ADDR_WIDTH and mem_rd_data in DATA_WIDTH; read data is valid exactly 1 cycle after mem_rd_en.
REQ-011 SHALL have ports mem_wr_en out 1, mem_wr_addr out ADDR_WIDTH and mem_wr_data out DATA_WIDTH.
REQ-012 SHALL have ports busy out 1, done out 1 (1-cycle pulse) and err out 1 (1-cycle pulse).

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, READ, DRAIN, WRITE and FIN.
REQ-014 SHALL drive cmd_ready=1 only in IDLE, and SHALL capture all cmd_* fields on the cycle cmd_valid&&cmd_ready, then go to CHECK.
REQ-015 SHALL, in CHECK, detect an illegal job (stride==0, dim==0, pool_log2==3, or pool>dim), pulse err for 1 cycle, perform no memory access and return to IDLE.
REQ-016 SHALL otherwise compute out_dim=(dim-pool)/stride+1 (integer floor) and go to READ with window (0,0) and offset (0,0).
REQ-017 SHALL, in READ, issue one read per cycle for pool*pool cycles at in_addr + (orow*stride+wr)*dim + (ocol*stride+wc), with wc fastest and all address arithmetic modulo 2^ADDR_WIDTH.
REQ-018 SHALL accumulate each returned mem_rd_data into a DATA_WIDTH+4-bit accumulator that is cleared at the first read of each window.
REQ-019 SHALL spend 1 cycle in DRAIN to absorb the last read return.
REQ-020 SHALL, in WRITE, assert mem_wr_en for 1 cycle with mem_wr_data = truncate(acc >> 2*pool_log2) and mem_wr_addr = out_addr + window_index, where window_index runs 0..out_dim^2-1 in row-major order.
REQ-021 SHALL, after WRITE, go to READ for the next window (ocol fastest, wrapping into orow); after the last window it SHALL go to FIN.
REQ-022 SHALL make per-window latency pool^2+2 cycles, with no idle cycle between windows.
REQ-023 SHALL pulse done for 1 cycle in FIN, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-024 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.
REQ-025 SHALL ignore cmd_valid while busy; the descriptor is not queued.
REQ-026 SHALL handle pool==1 as a 1-read window with copy semantics (shift 0).

Reset
REQ-027 SHALL, when rst is high at a clock edge, enter IDLE and clear counters and the accumulator.
REQ-028 SHALL hold cmd_ready=0, mem_rd_en=0, mem_wr_en=0, busy=0, done=0 and err=0 during reset.
REQ-029 SHALL drive cmd_ready=1 on the first cycle after reset deassertion.
REQ-030 SHALL, on reset mid-job, abort the job with no further writes and no done pulse, and SHALL discard any read return still in flight.

Structure
REQ-031 SHALL take the FSM state encoding, the pool_log2 encodings and the default parameters from shared package pool_pkg.
REQ-032 SHALL place the window/offset counters and read/write address arithmetic in sub-module pool_addr_gen; the FSM, accumulator and handshake SHALL stay in pool_sequencer.

Verification
REQ-033 SHALL cover: dim=4, pool=2, stride=2, in_addr=0x000, data[i]=i -> 4 writes at 0x100..0x103 = 2, 4, 10, 12; done 1 cycle after the last write; 24 cycles from CHECK to FIN.
REQ-034 SHALL cover: dim=3, pool=2, stride=1 -> 4 windows, 16 reads, reads for window 0 at in_addr+{0,1,3,4}.
REQ-035 SHALL cover: stride=0, or pool_log2=3, or dim=1 with pool=2 -> err pulse, zero mem_rd_en/mem_wr_en, cmd_ready=1 again within 2 cycles.
REQ-036 SHALL cover: in_addr=0xFFE, dim=2, pool=2 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001 (wrap).
REQ-037 SHALL cover: rst asserted during the READ of window 1 -> no mem_wr_en and no done afterwards, idle outputs next cycle; a new job then completes normally.
REQ-038 SHALL cover: all inputs 0xFFFFFFFF, pool=4 -> output 0xFFFFFFFF (no accumulator overflow).
